// File: rtl/regfile_dumper_if.sv
// Handshake/bus bundle between the register-file dumper, the regfile read port and the word sink.
interface regfile_dumper_if #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] first_reg;
    logic [ADDRESS_WIDTH-1:0] last_reg;
    logic [ADDRESS_WIDTH-1:0] rf_ad;
    logic [DATA_WIDTH-1:0]    rf_rd;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic [ADDRESS_WIDTH-1:0] out_addr;
    logic                     out_last;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, first_reg, last_reg, rf_rd, out_ready,
        output rf_ad, out_valid, out_data, out_addr, out_last, busy, done
    );

    modport slave (
        output start, first_reg, last_reg, rf_rd, out_ready,
        input  rf_ad, out_valid, out_data, out_addr, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dumper.sv
// Walks a (wrapping) register index range through one regfile read port and
// streams each captured word out on a valid/ready channel.
module regfile_dumper #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_dumper_if.master        bus
);
    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cur_q, cur_d;
    logic [AW-1:0]   last_q, last_d;
    logic [DW-1:0]   data_q, data_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            olast_q, olast_d;
    logic [AW-1:0]   rf_ad_q, rf_ad_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            olast_q <= 1'b0;
            rf_ad_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            olast_q <= olast_d;
            rf_ad_q <= rf_ad_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        data_d  = data_q;
        addr_d  = addr_q;
        olast_d = olast_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cur_d   = bus.first_reg;
                    last_d  = bus.last_reg;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                data_d  = bus.rf_rd;
                addr_d  = cur_q;
                olast_d = (cur_q == last_q);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    if (olast_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + AW'(1);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rf_ad_d = (state_d == ST_IDLE) ? '0 : cur_d;
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d == ST_READ) || (state_d == ST_SEND);
        done_d  = (state_d == ST_DONE);
    end

    assign bus.rf_ad     = rf_ad_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_last  = olast_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
